// File: rtl/matrix_mult_seq_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Optional feature: define MATRIX_MULT_SATURATE_EN for clamping plus overflow flag.
package matrix_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int DIM_DEF = 4;
   localparam int DW_DEF  = 16;

   // Element [r][c] sits at bit (r*dim + c)*dw of a flat matrix bus.
   function automatic int elem_lsb(input int r, input int c, input int dim, input int dw);
      return (r * dim + c) * dw;
   endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Flat-bus matrix operation port bundle: start/busy/done handshake plus operands and result.
// Optional feature macro MATRIX_MULT_SATURATE_EN only changes how ovf is driven.
interface matrix_mult_seq_if #(
   parameter int DIM = matrix_pkg::DIM_DEF,
   parameter int DW  = matrix_pkg::DW_DEF
);

   logic                    enable;
   logic [DIM*DIM*DW-1:0]   m1;
   logic [DIM*DIM*DW-1:0]   m2;
   logic [DIM*DIM*DW-1:0]   m_out;
   logic                    busy;
   logic                    done;
   logic                    ovf;

   modport master (
      output enable, m1, m2,
      input  m_out, busy, done, ovf
   );

   modport slave (
      input  enable, m1, m2,
      output m_out, busy, done, ovf
   );

endinterface

// File: rtl/matrix_mult_seq_mac_unit.sv
// Single multiply-accumulate lane; acc presents the running sum including the current product.
// Optional feature macro MATRIX_MULT_SATURATE_EN is not used here.
module mac_unit
   import matrix_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int ACC_W = 2 * DW_DEF + 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   input  logic             clr,
   input  logic             en,
   output logic [ACC_W-1:0] acc
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;

   assign acc = acc_q + ACC_W'(a) * ACC_W'(b);

   // clr wins over en so the final MAC of an element also restarts the sum.
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential DIM x DIM unsigned matrix multiplier, one MAC per clock, start/busy/done handshake.
// Optional feature macro MATRIX_MULT_SATURATE_EN: clamp elements to 2^DW-1 and report ovf.
module matrix_mult_seq
   import matrix_pkg::*;
#(
   parameter int DIM   = DIM_DEF,
   parameter int DW    = DW_DEF,
   parameter int ACC_W = 2 * DW + $clog2(DIM)
) (
   input  logic             clk,
   input  logic             reset,
   matrix_mult_seq_if.slave bus
);

   localparam int CW = $clog2(DIM);
   localparam int BW = DIM * DIM * DW;
   localparam logic [CW-1:0] LAST = CW'(DIM - 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  row_q, row_d;
   logic [CW-1:0]  col_q, col_d;
   logic [CW-1:0]  k_q, k_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [BW-1:0]  m_out_q;
   logic [BW-1:0]  a_q, b_q, res_q;

   logic             cap, wr, load_out;
   logic             mac_clr, mac_en;
   logic [DW-1:0]    a_el, b_el;
   logic [ACC_W-1:0] mac_acc;

`ifdef MATRIX_MULT_SATURATE_EN
   localparam logic [ACC_W-1:0] MAX_ACC = (ACC_W'(1) << DW) - ACC_W'(1);
`endif

   function automatic logic [DW-1:0] fit_elem(input logic [ACC_W-1:0] v);
`ifdef MATRIX_MULT_SATURATE_EN
      return (v > MAX_ACC) ? {DW{1'b1}} : v[DW-1:0];
`else
      return DW'(v);
`endif
   endfunction

   assign a_el = a_q[elem_lsb(int'(row_q), int'(k_q), DIM, DW) +: DW];
   assign b_el = b_q[elem_lsb(int'(k_q), int'(col_q), DIM, DW) +: DW];

   mac_unit #(
      .DW    (DW),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .a     (a_el),
      .b     (b_el),
      .clr   (mac_clr),
      .en    (mac_en),
      .acc   (mac_acc)
   );

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      k_d      = k_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cap      = 1'b0;
      wr       = 1'b0;
      load_out = 1'b0;
      mac_clr  = 1'b0;
      mac_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.enable) begin
               cap     = 1'b1;
               mac_clr = 1'b1;
               row_d   = '0;
               col_d   = '0;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            mac_en = 1'b1;
            if (k_q == LAST) begin
               // Element finished this cycle: store it and restart the sum.
               wr      = 1'b1;
               mac_clr = 1'b1;
               k_d     = '0;
               if (col_q == LAST) begin
                  col_d = '0;
                  if (row_q == LAST) begin
                     row_d   = '0;
                     state_d = DONE;
                  end else begin
                     row_d = row_q + CW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end else begin
               k_d = k_q + CW'(1);
            end
         end
         DONE: begin
            load_out = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         m_out_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         if (load_out) begin
            m_out_q <= res_q;
         end
      end
   end

   // Operand and result buffers carry no reset; they are always written before use.
   always_ff @(posedge clk) begin
      if (cap) begin
         a_q <= bus.m1;
         b_q <= bus.m2;
      end
      if (wr) begin
         res_q[elem_lsb(int'(row_q), int'(col_q), DIM, DW) +: DW] <= fit_elem(mac_acc);
      end
   end

`ifdef MATRIX_MULT_SATURATE_EN
   logic sat_q;
   logic ovf_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (cap) begin
            sat_q <= 1'b0;
         end else if (wr && (mac_acc > MAX_ACC)) begin
            sat_q <= 1'b1;
         end
         if (load_out) begin
            ovf_q <= sat_q;
         end
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.m_out = m_out_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Scoreboard bench for matrix_mult_seq: a DIM=4/DW=16 and a DIM=2/DW=8 instance checked
// against a plain-arithmetic reference model (honours MATRIX_MULT_SATURATE_EN).
module tb_matrix_mult_seq;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_tot = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [255:0] m;
      logic         o;
      int           cyc;
   } exp_t;

   exp_t q4[$];
   exp_t q2[$];

   matrix_mult_seq_if #(.DIM(4), .DW(16)) if4();
   matrix_mult_seq_if #(.DIM(2), .DW(8))  if2();

   matrix_mult_seq #(.DIM(4), .DW(16)) dut4 (.clk(clk), .reset(reset), .bus(if4));
   matrix_mult_seq #(.DIM(2), .DW(8))  dut2 (.clk(clk), .reset(reset), .bus(if2));

   function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   // Reference: textbook triple loop on integers, then wrap or clamp each element.
   function automatic exp_t model(input logic [255:0] a, input logic [255:0] b,
                                  input int dim, input int dw);
      exp_t   e;
      longint mx;
      longint s;
      longint ea;
      longint eb;
      mx = (longint'(1) << dw) - 1;
      e.m = '0;
      e.o = 1'b0;
      e.cyc = 0;
      for (int i = 0; i < dim; i++) begin
         for (int j = 0; j < dim; j++) begin
            s = 0;
            for (int k = 0; k < dim; k++) begin
               ea = longint'(a >> ((i * dim + k) * dw)) & mx;
               eb = longint'(b >> ((k * dim + j) * dw)) & mx;
               s += ea * eb;
            end
`ifdef MATRIX_MULT_SATURATE_EN
            if (s > mx) begin
               s = mx;
               e.o = 1'b1;
            end
`else
            s = s & mx;
`endif
            for (int t = 0; t < dw; t++) e.m[(i * dim + j) * dw + t] = s[t];
         end
      end
      return e;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic start4(input logic [255:0] a, input logic [255:0] b);
      exp_t e;
      @(negedge clk);
      if4.m1 = a;
      if4.m2 = b;
      if4.enable = 1'b1;
      e = model(a, b, 4, 16);
      e.cyc = cyc + 66;
      q4.push_back(e);
      @(negedge clk);
      if4.enable = 1'b0;
   endtask

   task automatic start2(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(negedge clk);
      if2.m1 = a;
      if2.m2 = b;
      if2.enable = 1'b1;
      e = model({224'd0, a}, {224'd0, b}, 2, 8);
      e.cyc = cyc + 10;
      q2.push_back(e);
      @(negedge clk);
      if2.enable = 1'b0;
   endtask

   task automatic wait4(input int bound);
      for (int i = 0; i < bound && q4.size() != 0; i++) @(negedge clk);
      chk("dim4_pending_after_bound", q4.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait2(input int bound);
      for (int i = 0; i < bound && q2.size() != 0; i++) @(negedge clk);
      chk("dim2_pending_after_bound", q2.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   logic prev_done4 = 1'b0;
   logic prev_done2 = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (if4.done) begin
         chk("dim4_done_consecutive", prev_done4, 1'b0);
         if (q4.size() == 0) begin
            chk("dim4_unexpected_done", if4.done, 1'b0);
         end else begin
            e = q4.pop_front();
            chk("dim4_m_out", if4.m_out, e.m);
            chk("dim4_ovf", if4.ovf, e.o);
            chk("dim4_done_edge", cyc, e.cyc);
            chk("dim4_busy_at_done", if4.busy, 1'b0);
         end
      end
      prev_done4 = if4.done;
   end

   always @(negedge clk) begin
      exp_t e;
      if (if2.done) begin
         chk("dim2_done_consecutive", prev_done2, 1'b0);
         if (q2.size() == 0) begin
            chk("dim2_unexpected_done", if2.done, 1'b0);
         end else begin
            e = q2.pop_front();
            chk("dim2_m_out", {224'd0, if2.m_out}, e.m);
            chk("dim2_ovf", if2.ovf, e.o);
            chk("dim2_done_edge", cyc, e.cyc);
         end
      end
      prev_done2 = if2.done;
   end

   initial begin
      logic [255:0] id;
      logic [255:0] ramp;
      logic [255:0] ones;
      logic [255:0] full;
      exp_t e;
      id = '0;
      ramp = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r == c) id[(r*4+c)*16 +: 16] = 16'd1;
            ramp[(r*4+c)*16 +: 16] = 16'(r * 4 + c);
         end
      end
      ones = {16{16'h0001}};
      full = {16{16'hFFFF}};
      if4.enable = 1'b0;
      if4.m1 = '0;
      if4.m2 = '0;
      if2.enable = 1'b0;
      if2.m1 = '0;
      if2.m2 = '0;

      repeat (2) @(negedge clk);
      chk("rst_dim4_m_out", if4.m_out, 0);
      chk("rst_dim4_busy", if4.busy, 0);
      chk("rst_dim4_done", if4.done, 0);
      chk("rst_dim4_ovf", if4.ovf, 0);
      chk("rst_dim2_m_out", {224'd0, if2.m_out}, 0);
      chk("rst_dim2_busy", if2.busy, 0);
      chk("rst_dim2_done", if2.done, 0);
      chk("rst_dim2_ovf", if2.ovf, 0);
      reset = 1'b1;

      start4(id, ramp);
      repeat (5) @(negedge clk);
      chk("dim4_busy_mid_run", if4.busy, 1'b1);
      wait4(200);

      start4(ones, ones);
      wait4(200);

      start4(full, full);
      wait4(200);

      // Enable pulses and an operand change while running must not disturb the result.
      start4(rnd256(), rnd256());
      repeat (8) @(negedge clk);
      if4.m1 = rnd256();
      if4.enable = 1'b1;
      @(negedge clk);
      if4.enable = 1'b0;
      repeat (29) @(negedge clk);
      if4.m2 = rnd256();
      if4.enable = 1'b1;
      @(negedge clk);
      if4.enable = 1'b0;
      wait4(200);
      repeat (80) @(negedge clk);

      // Asynchronous abort in the middle of RUN.
      start4(rnd256(), rnd256());
      repeat (28) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_m_out", if4.m_out, 0);
      chk("abort_busy", if4.busy, 0);
      chk("abort_done", if4.done, 0);
      q4.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (70) @(negedge clk);
      start4(rnd256(), rnd256());
      wait4(200);

      for (int n = 0; n < 3; n++) begin
         start4(rnd256(), rnd256());
         wait4(200);
      end

      // DIM=2 worked example with enable held for a back-to-back second run.
      @(negedge clk);
      if2.m1 = 32'h04030201;
      if2.m2 = 32'h08070605;
      if2.enable = 1'b1;
      e.m = {224'd0, 32'h322B1613};
      e.o = 1'b0;
      e.cyc = cyc + 10;
      q2.push_back(e);
      e.cyc = cyc + 20;
      q2.push_back(e);
      repeat (12) @(negedge clk);
      if2.enable = 1'b0;
      wait2(100);

      for (int n = 0; n < 4; n++) begin
         start2($urandom, $urandom);
         wait2(100);
      end
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
